// File: rtl/cam_cfg_sequencer.sv
// Camera power-up and register-table sequencer: drives pwd/rst through the boot
// timing, then walks a sync ROM table issuing SCCB writes with NACK retry.
module cam_cfg_sequencer #(
    parameter int unsigned RST_HOLD_CYC  = 25000,
    parameter int unsigned BOOT_WAIT_CYC = 75000,
    parameter int unsigned MS_CYC        = 25000,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned ROM_AW        = 8
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic              cfg_start_i,
    output logic              cam_pwd_o,
    output logic              cam_rst_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              sccb_req_o,
    output logic [7:0]        sccb_reg_o,
    output logic [7:0]        sccb_val_o,
    input  logic              sccb_ack_i,
    input  logic              sccb_done_i,
    input  logic              sccb_nack_i,
    output logic              cfg_busy_o,
    output logic              cfg_done_o,
    output logic              cfg_err_o,
    output logic [ROM_AW-1:0] cfg_idx_o
);

    localparam int unsigned WAIT_MAX = (RST_HOLD_CYC > BOOT_WAIT_CYC) ? RST_HOLD_CYC : BOOT_WAIT_CYC;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned DLY_W    = $clog2(255 * MS_CYC + 1);
    localparam int unsigned TRY_W    = $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_PWR,
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state, state_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_n;
    logic [DLY_W-1:0]    dly_cnt, dly_n;
    logic [TRY_W-1:0]    tries, tries_n;
    logic [ROM_AW-1:0]   idx, idx_n;
    logic [7:0]          reg_q, reg_n;
    logic [7:0]          val_q, val_n;

    // State and datapath registers; synchronous reset restarts the power sequence
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state    <= S_PWR;
            wait_cnt <= '0;
            dly_cnt  <= '0;
            tries    <= '0;
            idx      <= '0;
            reg_q    <= '0;
            val_q    <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            dly_cnt  <= dly_n;
            tries    <= tries_n;
            idx      <= idx_n;
            reg_q    <= reg_n;
            val_q    <= val_n;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        dly_n   = dly_cnt;
        tries_n = tries;
        idx_n   = idx;
        reg_n   = reg_q;
        val_n   = val_q;
        case (state)
            S_PWR: begin
                if (wait_cnt == WAIT_W'(RST_HOLD_CYC - 1)) begin
                    state_n = S_BOOT;
                    wait_n  = '0;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end
            S_BOOT: begin
                if (wait_cnt == WAIT_W'(BOOT_WAIT_CYC - 1)) begin
                    state_n = S_FETCH;
                    wait_n  = '0;
                    idx_n   = '0;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end
            S_FETCH: begin
                state_n = S_DECODE;
            end
            S_DECODE: begin
                tries_n = '0;
                if (rom_data_i == 16'hFFFF) begin
                    state_n = S_DONE;
                end else if (rom_data_i[15:8] == 8'hF0) begin
                    if (rom_data_i[7:0] == 8'h00) begin
                        state_n = S_NEXT;
                    end else begin
                        // Loaded with N-1 so DELAY occupies exactly val*MS_CYC cycles
                        dly_n   = DLY_W'(32'(rom_data_i[7:0]) * MS_CYC - 32'd1);
                        state_n = S_DELAY;
                    end
                end else begin
                    reg_n   = rom_data_i[15:8];
                    val_n   = rom_data_i[7:0];
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (sccb_ack_i) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sccb_done_i) begin
                    if (sccb_nack_i) begin
                        if (32'(tries) + 32'd1 >= MAX_RETRY) begin
                            state_n = S_ERR;
                        end else begin
                            tries_n = tries + TRY_W'(1);
                            state_n = S_WRITE;
                        end
                    end else begin
                        tries_n = '0;
                        state_n = S_NEXT;
                    end
                end
            end
            S_DELAY: begin
                if (dly_cnt == '0) begin
                    state_n = S_NEXT;
                end else begin
                    dly_n = dly_cnt - DLY_W'(1);
                end
            end
            S_NEXT: begin
                if (idx == '1) begin
                    state_n = S_ERR;
                end else begin
                    idx_n   = idx + ROM_AW'(1);
                    state_n = S_FETCH;
                end
            end
            S_DONE, S_ERR: begin
                if (cfg_start_i) begin
                    state_n = S_PWR;
                    wait_n  = '0;
                    dly_n   = '0;
                    tries_n = '0;
                    idx_n   = '0;
                end
            end
            default: begin
                state_n = S_PWR;
            end
        endcase
    end

    // Outputs are pure functions of state so reset/rerun takes effect the very next cycle
    assign cam_pwd_o  = (state == S_PWR);
    assign cam_rst_o  = (state != S_PWR);
    assign rom_addr_o = idx;
    assign sccb_req_o = (state == S_WRITE);
    assign sccb_reg_o = reg_q;
    assign sccb_val_o = val_q;
    assign cfg_busy_o = (state != S_DONE) && (state != S_ERR);
    assign cfg_done_o = (state == S_DONE);
    assign cfg_err_o  = (state == S_ERR);
    assign cfg_idx_o  = idx;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Scoreboard bench for cam_cfg_sequencer: a table-walking reference model queues the
// expected SCCB writes and final outcome; independent monitors pop and compare.
module tb_cam_cfg_sequencer;

    localparam int RST_HOLD  = 10;
    localparam int BOOT_WAIT = 20;
    localparam int MS        = 5;
    localparam int RETRY     = 3;
    localparam int AW        = 2;
    localparam int DEPTH     = 4;

    typedef struct packed {
        logic [15:0] w;
        logic        nack;
    } wr_t;

    typedef struct packed {
        logic        done;
        logic [1:0]  idx;
    } out_t;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cam_pwd, cam_rst;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data = '0;
    logic          sccb_req;
    logic [7:0]    sccb_reg, sccb_val;
    logic          sccb_ack = 1'b0;
    logic          sccb_done = 1'b0;
    logic          sccb_nack = 1'b0;
    logic          cfg_busy, cfg_done, cfg_err;
    logic [AW-1:0] cfg_idx;

    logic [15:0]   rom [DEPTH];
    int            nk [DEPTH];
    wr_t           exp_w [$];
    out_t          exp_out [$];
    int            req_cyc [$];
    int            ok_cyc [$];
    int            cyc = 0;
    int            ok_cnt = 0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    cam_cfg_sequencer #(
        .RST_HOLD_CYC (RST_HOLD),
        .BOOT_WAIT_CYC(BOOT_WAIT),
        .MS_CYC       (MS),
        .MAX_RETRY    (RETRY),
        .ROM_AW       (AW)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (sys_rst),
        .cfg_start_i(cfg_start),
        .cam_pwd_o  (cam_pwd),
        .cam_rst_o  (cam_rst),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .sccb_req_o (sccb_req),
        .sccb_reg_o (sccb_reg),
        .sccb_val_o (sccb_val),
        .sccb_ack_i (sccb_ack),
        .sccb_done_i(sccb_done),
        .sccb_nack_i(sccb_nack),
        .cfg_busy_o (cfg_busy),
        .cfg_done_o (cfg_done),
        .cfg_err_o  (cfg_err),
        .cfg_idx_o  (cfg_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: walk the table by its rules, queue writes (with the NACK
    // response the SCCB model will give) and the final outcome.
    task automatic build_model();
        logic ok;
        exp_w.delete();
        exp_out.delete();
        req_cyc.delete();
        ok_cyc.delete();
        for (int i = 0; i < DEPTH; i++) begin
            if (rom[i] == 16'hFFFF) begin
                exp_out.push_back({1'b1, 2'(i)});
                return;
            end
            if (rom[i][15:8] == 8'hF0) continue;
            ok = 1'b0;
            for (int a = 0; a < RETRY; a++) begin
                exp_w.push_back({rom[i], (a < nk[i]) ? 1'b1 : 1'b0});
                if (a >= nk[i]) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                exp_out.push_back({1'b0, 2'(i)});
                return;
            end
        end
        exp_out.push_back({1'b0, 2'(DEPTH - 1)});
    endtask

    // SCCB master model and write monitor
    initial begin
        logic [15:0] got;
        logic        acc;
        wr_t         e;
        forever begin
            @(negedge clk);
            if (sccb_req === 1'b1 && !sys_rst) begin
                got = {sccb_reg, sccb_val};
                sccb_ack = 1'b1;
                @(posedge clk);
                acc = !sys_rst;
                @(negedge clk);
                sccb_ack = 1'b0;
                if (acc) begin
                    req_cyc.push_back(cyc);
                    if (exp_w.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got %h expected none", got);
                        e = {got, 1'b0};
                    end else begin
                        e = exp_w.pop_front();
                        check("write_regval", 32'(got), 32'(e.w));
                    end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    sccb_done = 1'b1;
                    sccb_nack = e.nack;
                    if (!e.nack) begin
                        ok_cnt++;
                        ok_cyc.push_back(cyc);
                    end
                    @(negedge clk);
                    sccb_done = 1'b0;
                    sccb_nack = 1'b0;
                end
            end
        end
    end

    // Outcome monitor: compare status when the sequence finishes
    initial begin
        logic prev = 1'b0;
        logic fin;
        out_t o;
        forever begin
            @(negedge clk);
            fin = cfg_done | cfg_err;
            if (fin && !prev) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_outcome: got done=%0b err=%0b expected none", cfg_done, cfg_err);
                end else begin
                    o = exp_out.pop_front();
                    check("outcome_done", 32'(cfg_done), 32'(o.done));
                    check("outcome_err", 32'(cfg_err), 32'(!o.done));
                    check("outcome_idx", 32'(cfg_idx), 32'(o.idx));
                    check("outcome_busy", 32'(cfg_busy), 32'd0);
                end
            end
            prev = fin;
        end
    end

    task automatic wait_outcome(input string name);
        int n = 0;
        while (exp_out.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(exp_out.size()), 32'd0);
        check({name, "_writes_left"}, 32'(exp_w.size()), 32'd0);
        repeat (5) @(negedge clk);
        check({name, "_req_idle"}, 32'(sccb_req), 32'd0);
        check({name, "_final_hold"}, 32'(cfg_done | cfg_err), 32'd1);
        exp_out.delete();
        exp_w.delete();
    endtask

    task automatic start_run();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("rerun_pwd", 32'(cam_pwd), 32'd1);
        check("rerun_rst", 32'(cam_rst), 32'd0);
        check("rerun_done", 32'(cfg_done), 32'd0);
        check("rerun_err", 32'(cfg_err), 32'd0);
        check("rerun_busy", 32'(cfg_busy), 32'd1);
    endtask

    task automatic set_rom(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] d, input int n0);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
        nk[0] = n0; nk[1] = 0; nk[2] = 0; nk[3] = 0;
    endtask

    task automatic random_rom();
        int r;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      rom[i] = {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
            else if (r < 7) rom[i] = {8'hF0, 8'($urandom_range(0, 6))};
            else            rom[i] = 16'hFFFF;
            r = $urandom_range(0, 9);
            nk[i] = (r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, 2)) : 3;
        end
    endtask

    initial begin
        int n;
        int c0;
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int n;
        int c0;

        // Reset state and power-up timing, table with a 2 ms delay entry
        set_rom(16'h1280, 16'hF002, 16'h1101, 16'hFFFF, 0);
        repeat (3) @(negedge clk);
        check("rst_pwd", 32'(cam_pwd), 32'd1);
        check("rst_rst", 32'(cam_rst), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_req", 32'(sccb_req), 32'd0);
        check("rst_regval", 32'({sccb_reg, sccb_val}), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd1);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_idx", 32'(cfg_idx), 32'd0);
        build_model();
        sys_rst = 1'b0;
        for (int s = 0; s <= 32; s++) begin
            if (s != 0) @(negedge clk);
            check("pwr_pwd", 32'(cam_pwd), (s < RST_HOLD) ? 32'd1 : 32'd0);
            check("pwr_rst", 32'(cam_rst), (s < RST_HOLD) ? 32'd0 : 32'd1);
            check("first_req", 32'(sccb_req), (s == RST_HOLD + BOOT_WAIT + 2) ? 32'd1 : 32'd0);
            if (s == RST_HOLD + BOOT_WAIT) check("first_addr", 32'(rom_addr), 32'd0);
        end
        wait_outcome("table_done");
        check("gap_samples", 32'(req_cyc.size() >= 2 && ok_cyc.size() >= 1), 32'd1);
        if (req_cyc.size() >= 2 && ok_cyc.size() >= 1)
            check("delay_gap_ok", 32'((req_cyc[1] - ok_cyc[0]) >= 2 * MS && (req_cyc[1] - ok_cyc[0]) <= 25), 32'd1);

        // Two NACKs then ACK; start pulse during the delay must be ignored
        set_rom(16'h1280, 16'hF002, 16'h1101, 16'hFFFF, 2);
        build_model();
        start_run();
        c0 = ok_cnt;
        n = 0;
        while (ok_cnt == c0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("retry_ack_seen", 32'(ok_cnt != c0), 32'd1);
        repeat (6) @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("start_in_delay_busy", 32'(cfg_busy), 32'd1);
        check("start_in_delay_pwd", 32'(cam_pwd), 32'd0);
        check("start_in_delay_rst", 32'(cam_rst), 32'd1);
        wait_outcome("retry_ok");

        // Three NACKs exhaust retries
        set_rom(16'h1280, 16'hF002, 16'h1101, 16'hFFFF, 3);
        build_model();
        start_run();
        wait_outcome("retry_err");

        // Missing terminator
        set_rom(16'h1280, 16'h1101, 16'h1301, 16'h1401, 0);
        build_model();
        start_run();
        wait_outcome("no_term");

        // Reset while a write request is pending
        set_rom(16'h2233, 16'h4455, 16'hFFFF, 16'hFFFF, 0);
        build_model();
        start_run();
        n = 0;
        while (sccb_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_before_reset", 32'(sccb_req), 32'd1);
        sys_rst = 1'b1;
        @(negedge clk);
        check("midrst_req", 32'(sccb_req), 32'd0);
        check("midrst_pwd", 32'(cam_pwd), 32'd1);
        check("midrst_rst", 32'(cam_rst), 32'd0);
        check("midrst_busy", 32'(cfg_busy), 32'd1);
        exp_w.delete();
        exp_out.delete();
        repeat (2) @(negedge clk);
        random_rom();
        build_model();
        sys_rst = 1'b0;
        wait_outcome("after_reset");

        // Randomized tables
        for (int t = 0; t < 25; t++) begin
            random_rom();
            build_model();
            start_run();
            wait_outcome("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
